// File: rtl/bw_pixel_packer.sv
// Thresholds luma sums to black/white pixels, packs 8 pixels per byte (MSB first)
// and hands bytes out on a valid/ready stream with end-of-frame marking.
module bw_pixel_packer #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_luma_sum,
    input  logic [7:0]  threshold,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        frame_done
);

    localparam int unsigned PIX_TOTAL = IMG_W * IMG_H;
    localparam int unsigned CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] pix_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       pack_reg;
    logic [7:0]       pack_next;
    logic [7:0]       thr_lat;
    logic [7:0]       thr_eff;
    logic [7:0]       gray;
    logic             bw;
    logic             accept;
    logic             drain;
    logic             last_pix;
    logic             byte_done;
    logic             unused_lsbs;

    // Low luma bits are dropped by the truncating divide-by-128.
    assign unused_lsbs = ^in_luma_sum[6:0];

    // Handshake: never accept while a byte would be stranded or the frame is draining.
    assign in_ready  = rst_n && (state != DRAIN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_pix  = (pix_cnt == LAST_PIX);
    assign byte_done = accept && (bit_cnt == 3'd7);

    // Threshold is live for the first pixel, frozen for the rest of the frame.
    assign gray    = in_luma_sum[14:7];
    assign thr_eff = (state == IDLE) ? threshold : thr_lat;
    assign bw      = (gray >= thr_eff);

    // Insert the new bit at its MSB-first position; a fresh byte starts from zero.
    always_comb begin
        pack_next = (bit_cnt == 3'd0) ? 8'h00 : pack_reg;
        pack_next[3'd7 - bit_cnt] = bw;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing: IDLE until first pixel, ACTIVE until last, DRAIN until last byte leaves.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = last_pix ? DRAIN : ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && last_pix) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, packing register, threshold latch and the output byte holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            bit_cnt    <= 3'd0;
            pack_reg   <= 8'h00;
            thr_lat    <= 8'h00;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= drain && out_last;
            if (accept) begin
                pack_reg <= pack_next;
                bit_cnt  <= bit_cnt + 3'd1;
                pix_cnt  <= last_pix ? '0 : pix_cnt + CNT_W'(1);
                if (state == IDLE) begin
                    thr_lat <= threshold;
                end
            end
            if (byte_done) begin
                out_byte  <= pack_next;
                out_valid <= 1'b1;
                out_last  <= last_pix;
            end else if (drain) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bw_pixel_packer.sv
// Directed self-checking bench for bw_pixel_packer at the default 128x128 size.
module tb_bw_pixel_packer;

    localparam int unsigned PIX   = 128 * 128;
    localparam int unsigned BYTES = PIX / 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_luma_sum;
    logic [7:0]  threshold;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        frame_done;

    int checks;
    int errors;

    logic [7:0] mon_bytes[$];
    int         mon_last_cnt;
    int         mon_last_idx;
    int         mon_done_cnt;

    bw_pixel_packer #(.IMG_W(128), .IMG_H(128)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_luma_sum(in_luma_sum),
        .threshold(threshold),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_byte(out_byte),
        .out_last(out_last),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Record every byte that will be taken at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (out_last) begin
                mon_last_cnt++;
                mon_last_idx = mon_bytes.size();
            end
            mon_bytes.push_back(out_byte);
        end
        if (frame_done) mon_done_cnt++;
    end

    task automatic clear_mon();
        mon_bytes.delete();
        mon_last_cnt = 0;
        mon_last_idx = -1;
        mon_done_cnt = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Present one pixel and return 1 time unit after the edge that accepts it.
    task automatic send_pixel(input logic [14:0] s);
        int budget;
        budget      = 0;
        in_valid    = 1'b1;
        in_luma_sum = s;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_pixel_timeout: in_ready stayed %0b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b need 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b need 0", out_valid); end
        checks++;
        if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte: got %h need 00", out_byte); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b need 0", out_last); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b need 0", frame_done); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b need 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_pattern_aa();
        apply_reset();
        threshold = 8'd128;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_pixel((i % 2 == 0) ? 15'h4000 : 15'h3F80);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL aa_early_valid: got %0b need 0", out_valid); end
        send_pixel(15'h3F80);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL aa_latency_valid: got %0b need 1", out_valid); end
        checks++;
        if (out_byte !== 8'hAA) begin errors++; $display("FAIL aa_byte: got %h need aa", out_byte); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL aa_last: got %0b need 0", out_last); end
    endtask

    task automatic test_threshold_extremes();
        apply_reset();
        threshold = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_pixel(15'($urandom));
        in_valid = 1'b0;
        checks++;
        if (out_byte !== 8'hFF) begin errors++; $display("FAIL thr0_byte: got %h need ff", out_byte); end
        apply_reset();
        threshold = 8'd255;
        for (int i = 0; i < 8; i++) send_pixel((i % 2 == 0) ? 15'h7FFF : 15'h7F7F);
        in_valid = 1'b0;
        checks++;
        if (out_byte !== 8'hAA) begin errors++; $display("FAIL thr255_byte: got %h need aa", out_byte); end
    endtask

    task automatic test_threshold_latch();
        apply_reset();
        threshold = 8'd128;
        out_ready = 1'b1;
        send_pixel(15'h4000);
        threshold = 8'd0;
        for (int i = 0; i < 7; i++) send_pixel(15'h3F80);
        in_valid = 1'b0;
        checks++;
        if (out_byte !== 8'h80) begin errors++; $display("FAIL latch_byte0: got %h need 80", out_byte); end
        threshold = 8'd255;
        for (int i = 0; i < 8; i++) send_pixel(15'h4000);
        in_valid = 1'b0;
        checks++;
        if (out_byte !== 8'hFF) begin errors++; $display("FAIL latch_byte1: got %h need ff", out_byte); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        clear_mon();
        threshold = 8'd128;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_pixel(15'h4000);
        in_valid    = 1'b1;
        in_luma_sum = 15'h0000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d: got %0b need 0", c, in_ready); end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid c=%0d: got %0b need 1", c, out_valid); end
            checks++;
            if (out_byte !== 8'hFF) begin errors++; $display("FAIL stall_out_byte c=%0d: got %h need ff", c, out_byte); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_pixel(15'h0000);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (mon_bytes.size() != 2) begin errors++; $display("FAIL stall_byte_count: got %0d need 2", mon_bytes.size()); end
        checks++;
        if (mon_bytes[0] !== 8'hFF) begin errors++; $display("FAIL stall_first_byte: got %h need ff", mon_bytes[0]); end
        checks++;
        if (mon_bytes[1] !== 8'h00) begin errors++; $display("FAIL stall_second_byte: got %h need 00", mon_bytes[1]); end
        @(posedge clk); #1;
    endtask

    // Stream a whole frame of white pixels and verify framing of the byte stream.
    task automatic run_full_frame(input string tag);
        int bad;
        clear_mon();
        threshold = 8'd128;
        out_ready = 1'b1;
        for (int i = 0; i < int'(PIX); i++) send_pixel(15'h7FFF);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_drain_in_ready: got %0b need 0", tag, in_ready); end
        checks++;
        if (out_last !== 1'b1) begin errors++; $display("FAIL %s_final_last: got %0b need 1", tag, out_last); end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        bad = 0;
        foreach (mon_bytes[k]) if (mon_bytes[k] !== 8'hFF) bad++;
        checks++;
        if (mon_bytes.size() != int'(BYTES)) begin errors++; $display("FAIL %s_byte_count: got %0d need %0d", tag, mon_bytes.size(), BYTES); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_byte_values: %0d bytes not ff, need 0", tag, bad); end
        checks++;
        if (mon_last_cnt != 1) begin errors++; $display("FAIL %s_last_count: got %0d need 1", tag, mon_last_cnt); end
        checks++;
        if (mon_last_idx != int'(BYTES) - 1) begin errors++; $display("FAIL %s_last_index: got %0d need %0d", tag, mon_last_idx, BYTES - 1); end
        checks++;
        if (mon_done_cnt != 1) begin errors++; $display("FAIL %s_frame_done_count: got %0d need 1", tag, mon_done_cnt); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_in_ready: got %0b need 1", tag, in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        apply_reset();
        run_full_frame("frame");
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        threshold = 8'd128;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) send_pixel(15'h0000);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending_valid: got %0b need 1", out_valid); end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready: got %0b need 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %0b need 0", out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready: got %0b need 1", in_ready); end
        @(posedge clk); #1;
        run_full_frame("after_reset");
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_luma_sum  = 15'h0000;
        threshold    = 8'd128;
        out_ready    = 1'b1;
        checks       = 0;
        errors       = 0;
        clear_mon();

        test_reset();
        test_pattern_aa();
        test_threshold_extremes();
        test_threshold_latch();
        test_backpressure();
        test_full_frame();
        test_reset_midframe();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
